// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU control unit's memory port.
//   Owns a word-organised synchronous RAM (2**ADDR_WIDTH x 32). Reads are
//   started by a one-cycle init strobe, pass through WAIT_STATES idle cycles,
//   sample the RAM, and then raise a held ready with sign/zero-extended data.
//   Stores are byte-enabled and commit on the edge where they are presented.
// Ports:
//   clk       in   1   clock
//   reset     in   1   synchronous, active-high
//   addr      in   32  byte address (bits [ADDR_WIDTH+1:2] index RAM)
//   read_op   in   3   LB=0 LH=1 LW=2 LBU=4 LHU=5, others = no read
//   init      in   1   start a read with addr/read_op this cycle
//   write_op  in   2   SB=0 SH=1 SW=2 SNONE=3
//   wdata     in   32  store data, right-justified
//   rdata     out 32   extended load data, valid while ready=1
//   ready     out 1    read complete, held until next init or reset
//   fault     out 1    one-cycle pulse on a misaligned access
module mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [2:0]  read_op,
  input  logic        init,
  input  logic [1:0]  write_op,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        fault
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  localparam logic [2:0] OP_LB = 3'd0, OP_LH = 3'd1, OP_LW = 3'd2,
                         OP_LBU = 3'd4, OP_LHU = 3'd5;
  localparam logic [1:0] ST_SB = 2'd0, ST_SH = 2'd1, ST_SW = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_DONE} state_t;

  state_t state, state_next;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           ram_q;
  logic [ADDR_WIDTH+1:0] lat_addr;
  logic [2:0]            lat_op;
  logic                  lat_mis;
  logic [3:0]            cnt;

  logic        valid_op, start, load_mis, store_mis;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_ext;

  // Upper address bits are discarded on purpose (address wrap).
  logic unused_addr;
  assign unused_addr = ^addr[31:ADDR_WIDTH+2];

  assign valid_op = (read_op == OP_LB) || (read_op == OP_LH) || (read_op == OP_LW) ||
                    (read_op == OP_LBU) || (read_op == OP_LHU);
  assign start    = init && valid_op;

  assign load_mis = (((read_op == OP_LH) || (read_op == OP_LHU)) && addr[0]) ||
                    ((read_op == OP_LW) && (addr[1:0] != 2'b00));
  assign store_mis = ((write_op == ST_SH) && addr[0]) ||
                     ((write_op == ST_SW) && (addr[1:0] != 2'b00));

  // Byte enables and lane-replicated store data; misaligned stores get no enables.
  always_comb begin
    be    = 4'b0000;
    wlane = wdata;
    case (write_op)
      ST_SB: begin
        be    = 4'b0001 << addr[1:0];
        wlane = {4{wdata[7:0]}};
      end
      ST_SH: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
      end
      ST_SW: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (store_mis) be = 4'b0000;
  end

  // Single-port style RAM: byte-write plus read-first registered read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr[ADDR_WIDTH+1:2]][8*i +: 8] <= wlane[8*i +: 8];
    end
    if (state == S_READ) ram_q <= mem[lat_addr[ADDR_WIDTH+1:2]];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = (WS != 4'd0) ? S_WAIT : S_READ;
    end else begin
      case (state)
        S_WAIT:  if (cnt <= 4'd1) state_next = S_READ;
        S_READ:  state_next = S_DONE;
        default: state_next = state;
      endcase
    end
  end

  // Load extraction from the sampled word using the latched lane.
  always_comb begin
    byte_v   = ram_q[8*lat_addr[1:0] +: 8];
    half_v   = lat_addr[1] ? ram_q[31:16] : ram_q[15:0];
    load_ext = ram_q;
    case (lat_op)
      OP_LB:   load_ext = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_ext = {24'd0, byte_v};
      OP_LH:   load_ext = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_ext = {16'd0, half_v};
      default: load_ext = ram_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready    <= 1'b0;
      rdata    <= 32'd0;
      fault    <= 1'b0;
      cnt      <= 4'd0;
      lat_addr <= '0;
      lat_op   <= 3'd0;
      lat_mis  <= 1'b0;
    end else begin
      fault <= (start && load_mis) || store_mis;
      if (start) begin
        lat_addr <= addr[ADDR_WIDTH+1:0];
        lat_op   <= read_op;
        lat_mis  <= load_mis;
        cnt      <= WS;
        ready    <= 1'b0;
      end else begin
        if (state == S_WAIT) cnt <= cnt - 4'd1;
        // ram_q only changes in READ, so re-assigning here keeps rdata stable.
        if (state == S_DONE) begin
          ready <= 1'b1;
          rdata <= lat_mis ? 32'd0 : load_ext;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [2:0]  read_op;
  logic        init;
  logic [1:0]  write_op;
  logic [31:0] wdata;

  logic [31:0] rdata_v [3];
  logic        ready_v [3];
  logic        fault_v [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Index 0: WAIT_STATES=0, index 1: WAIT_STATES=1, index 2: WAIT_STATES=3.
  mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .addr(addr), .read_op(read_op), .init(init),
    .write_op(write_op), .wdata(wdata),
    .rdata(rdata_v[0]), .ready(ready_v[0]), .fault(fault_v[0]));
  mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut (
    .clk(clk), .reset(reset), .addr(addr), .read_op(read_op), .init(init),
    .write_op(write_op), .wdata(wdata),
    .rdata(rdata_v[1]), .ready(ready_v[1]), .fault(fault_v[1]));
  mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .addr(addr), .read_op(read_op), .init(init),
    .write_op(write_op), .wdata(wdata),
    .rdata(rdata_v[2]), .ready(ready_v[2]), .fault(fault_v[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    write_op = op; addr = a; wdata = d;
    tick;
    write_op = 2'd3;
  endtask

  task automatic do_load(input int sel, input logic [2:0] op, input logic [31:0] a,
                         output logic [31:0] rd, output int lat, output logic f0);
    read_op = op; addr = a; init = 1'b1;
    tick;
    init = 1'b0; read_op = 3'd7;
    f0 = fault_v[sel];
    check("ready_low_after_init", 32'(ready_v[sel]), 32'd0);
    lat = 0;
    while (!ready_v[sel] && lat < 40) begin
      tick;
      lat++;
    end
    if (!ready_v[sel]) check("ready_timeout", 32'd0, 32'd1);
    rd = rdata_v[sel];
  endtask

  logic [31:0] rd, held;
  int          lat;
  logic        f0;

  initial begin
    reset = 1'b1; addr = 32'd0; read_op = 3'd7; init = 1'b0;
    write_op = 2'd3; wdata = 32'd0;
    tick; tick;
    check("reset_ready", 32'(ready_v[1]), 32'd0);
    check("reset_rdata", rdata_v[1], 32'd0);
    check("reset_fault", 32'(fault_v[1]), 32'd0);
    reset = 1'b0;
    tick;

    // T1
    do_store(2'd2, 32'h10, 32'hDEADBEEF);
    check("sw_aligned_fault", 32'(fault_v[1]), 32'd0);
    do_load(1, 3'd2, 32'h10, rd, lat, f0);
    check("t1_latency", 32'(lat), 32'd3);
    check("t1_rdata", rd, 32'hDEADBEEF);
    check("t1_fault", 32'(f0), 32'd0);

    // T2
    do_store(2'd2, 32'h20, 32'h80FF7F01);
    do_load(1, 3'd0, 32'h23, rd, lat, f0); check("t2_lb", rd, 32'hFFFFFF80);
    do_load(1, 3'd4, 32'h23, rd, lat, f0); check("t2_lbu", rd, 32'h00000080);
    do_load(1, 3'd1, 32'h22, rd, lat, f0); check("t2_lh", rd, 32'hFFFF80FF);
    do_load(1, 3'd5, 32'h20, rd, lat, f0); check("t2_lhu", rd, 32'h00007F01);

    // T3
    do_store(2'd2, 32'h20, 32'h11223344);
    do_store(2'd0, 32'h21, 32'h000000AA);
    do_load(1, 3'd2, 32'h20, rd, lat, f0); check("t3_sb", rd, 32'h1122AA44);
    do_store(2'd1, 32'h22, 32'h0000BEEF);
    do_load(1, 3'd2, 32'h20, rd, lat, f0); check("t3_sh", rd, 32'hBEEFAA44);

    // T4
    do_store(2'd2, 32'h30, 32'h55667788);
    do_store(2'd2, 32'h31, 32'h12345678);
    check("t4_sw_mis_fault", 32'(fault_v[1]), 32'd1);
    tick;
    check("t4_fault_pulse_end", 32'(fault_v[1]), 32'd0);
    do_store(2'd1, 32'h31, 32'h0000FFFF);
    check("t4_sh_mis_fault", 32'(fault_v[1]), 32'd1);
    do_load(1, 3'd2, 32'h30, rd, lat, f0); check("t4_word_intact", rd, 32'h55667788);
    do_load(1, 3'd2, 32'h32, rd, lat, f0);
    check("t4_lw_mis_fault", 32'(f0), 32'd1);
    check("t4_lw_mis_rdata", rd, 32'd0);
    check("t4_lw_mis_latency", 32'(lat), 32'd3);

    // T5: back-to-back init restarts the read
    do_store(2'd2, 32'h40, 32'hAAAA0040);
    do_store(2'd2, 32'h44, 32'hBBBB0044);
    read_op = 3'd2; addr = 32'h40; init = 1'b1;
    tick;
    check("t5_ready_first", 32'(ready_v[1]), 32'd0);
    addr = 32'h44;
    tick;
    init = 1'b0; read_op = 3'd7;
    lat = 0;
    while (!ready_v[1] && lat < 40) begin tick; lat++; end
    check("t5_latency", 32'(lat), 32'd3);
    check("t5_rdata", rdata_v[1], 32'hBBBB0044);

    // T5: reset during WAIT
    read_op = 3'd2; addr = 32'h10; init = 1'b1;
    tick;
    init = 1'b0; read_op = 3'd7;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("t5_rst_ready", 32'(ready_v[1]), 32'd0);
    check("t5_rst_rdata", rdata_v[1], 32'd0);
    tick; tick; tick;
    check("t5_rst_idle_ready", 32'(ready_v[1]), 32'd0);
    do_load(1, 3'd2, 32'h10, rd, lat, f0); check("t5_ram_intact", rd, 32'hDEADBEEF);

    // Address wrap
    do_store(2'd2, 32'h1000, 32'hCAFEF00D);
    do_load(1, 3'd2, 32'h0, rd, lat, f0); check("wrap_alias", rd, 32'hCAFEF00D);

    // Read-first: store lands on the same edge the RAM is sampled (E2 for WAIT_STATES=1)
    do_store(2'd2, 32'h50, 32'h11111111);
    read_op = 3'd2; addr = 32'h50; init = 1'b1;
    tick;
    init = 1'b0; read_op = 3'd7;
    tick;
    write_op = 2'd2; wdata = 32'h22222222;
    tick;
    write_op = 2'd3;
    lat = 0;
    while (!ready_v[1] && lat < 40) begin tick; lat++; end
    check("read_first_old", rdata_v[1], 32'h11111111);
    do_load(1, 3'd2, 32'h50, rd, lat, f0); check("read_first_new", rd, 32'h22222222);

    // T6
    do_load(0, 3'd2, 32'h10, rd, lat, f0);
    check("t6_ws0_latency", 32'(lat), 32'd2);
    check("t6_ws0_rdata", rd, 32'hDEADBEEF);
    do_load(2, 3'd0, 32'h20, rd, lat, f0);
    check("t6_ws3_latency", 32'(lat), 32'd5);
    check("t6_ws3_rdata", rd, 32'h00000044);
    held = rd;
    for (int i = 0; i < 10; i++) begin
      tick;
      check("t6_hold_ready", 32'(ready_v[2]), 32'd1);
      check("t6_hold_rdata", rdata_v[2], held);
    end
    // invalid read_op on init is ignored
    read_op = 3'd3; init = 1'b1;
    tick;
    init = 1'b0; read_op = 3'd7;
    check("t6_invalid_op_ready", 32'(ready_v[2]), 32'd1);
    tick;
    check("t6_invalid_op_rdata", rdata_v[2], held);
    read_op = 3'd2; addr = 32'h10; init = 1'b1;
    tick;
    init = 1'b0; read_op = 3'd7;
    check("t6_next_init_drop", 32'(ready_v[2]), 32'd0);
    for (int i = 0; i < 8; i++) tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
